// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and types for the fetch/decode/execute sequencer.
// Holds the opcode encodings, the execution-unit index and the sequencer state enum.
package cpu_pkg;

    localparam int XLEN           = 32;
    localparam int REG_SELECT_LEN = 5;
    localparam int NUM_UNITS      = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Index doubles as the bit position in the unit enable/select vectors.
    typedef enum logic [1:0] {
        UNIT_LUI    = 2'd0,
        UNIT_AUIPC  = 2'd1,
        UNIT_OP_IMM = 2'd2,
        UNIT_OP     = 2'd3
    } unit_e;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_TRAP      = 3'd4
    } state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch bus between the sequencer (master) and memory (slave).
interface fetch_sequencer_if #(
    parameter int XLEN = cpu_pkg::XLEN
);
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_sequencer_decoder.sv
// Combinational opcode classifier: one-hot execution unit select plus illegal flag.
module opcode_decoder
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
) (
    input  logic [XLEN-1:0]      instruction,
    output logic [NUM_UNITS-1:0] unit_sel,
    output logic                 illegal
);

    logic unused_hi;
    assign unused_hi = ^instruction[XLEN-1:7];

    always_comb begin
        unit_sel = '0;
        illegal  = 1'b0;
        case (instruction[6:0])
            OPC_LUI:    unit_sel[UNIT_LUI]    = 1'b1;
            OPC_AUIPC:  unit_sel[UNIT_AUIPC]  = 1'b1;
            OPC_OP_IMM: unit_sel[UNIT_OP_IMM] = 1'b1;
            OPC_OP:     unit_sel[UNIT_OP]     = 1'b1;
            default:    illegal               = 1'b1;
        endcase
        // Compressed-style encodings never match a supported opcode.
        if (instruction[1:0] != 2'b11) begin
            unit_sel = '0;
            illegal  = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> WRITEBACK,
// with a sticky TRAP on unrecognised opcodes that only reset can leave.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_sequencer_if.master    bus,
    output logic [XLEN-1:0]      instruction,
    output logic [NUM_UNITS-1:0] unit_enable_n,
    output logic                 wb_we,
    output logic [XLEN-1:0]      pc,
    output logic                 illegal
);

    state_e                    state, state_nxt;
    logic [NUM_UNITS-1:0]      dec_sel;
    logic                      dec_illegal;
    logic [NUM_UNITS-1:0]      unit_sel;
    logic [REG_SELECT_LEN-1:0] rd;
    logic                      fetch_accept;

    opcode_decoder #(.XLEN(XLEN)) u_decoder (
        .instruction (instruction),
        .unit_sel    (dec_sel),
        .illegal     (dec_illegal)
    );

    assign rd           = instruction[11:7];
    assign fetch_accept = (state == ST_FETCH) && bus.mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        unit_enable_n = '1;
        wb_we         = 1'b0;
        bus.mem_req   = 1'b0;
        case (state)
            ST_FETCH: begin
                // Held low during reset even though the state register reads FETCH.
                bus.mem_req = rst_n;
                if (bus.mem_ack) state_nxt = ST_DECODE;
            end
            ST_DECODE:    state_nxt = dec_illegal ? ST_TRAP : ST_EXECUTE;
            ST_EXECUTE: begin
                unit_enable_n = ~unit_sel;
                state_nxt     = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                unit_enable_n = ~unit_sel;
                wb_we         = (rd != '0);
                state_nxt     = ST_FETCH;
            end
            ST_TRAP:      state_nxt = ST_TRAP;
            default:      state_nxt = ST_FETCH;
        endcase
    end

    assign bus.mem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instruction <= '0;
            unit_sel    <= '0;
            illegal     <= 1'b0;
        end else begin
            if (fetch_accept) instruction <= bus.mem_rdata;
            if (state == ST_DECODE) begin
                unit_sel <= dec_illegal ? '0 : dec_sel;
                if (dec_illegal) illegal <= 1'b1;
            end
            if (state == ST_WRITEBACK) pc <= pc + XLEN'(4);
        end
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter XLEN, default 32, datapath width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port mem_req  output  1  instruction fetch request.
REQ-007 SHALL have port mem_addr  output  XLEN  fetch address, equal to pc.
REQ-008 SHALL have port mem_ack  input  1  fetch data valid, sampled only while mem_req=1.
REQ-009 SHALL have port mem_rdata  input  XLEN  fetched instruction word.
REQ-010 SHALL have port instruction  output  XLEN  held instruction register, broadcast to execution units.
REQ-011 SHALL have port unit_enable_n  output  4  active-low unit enables: bit0 LUI, bit1 AUIPC, bit2 OP_IMM, bit3 OP.
REQ-012 SHALL have port wb_we  output  1  register-file write strobe, capturing output_register/output_register_data.
REQ-013 SHALL have port pc  output  XLEN  current program counter.
REQ-014 SHALL have port illegal  output  1  sticky illegal-instruction flag.

Function
REQ-015 SHALL implement states FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
REQ-016 FETCH: mem_req=1, mem_addr=pc; on a clock edge with mem_ack=1, instruction<=mem_rdata and go DECODE; otherwise stay in FETCH with no timeout.
REQ-017 DECODE: one cycle; classify instruction[6:0] as LUI 0110111, AUIPC 0010111, OP_IMM 0010011 or OP 0110011; go EXECUTE if recognised, else go TRAP.
REQ-018 An opcode with instruction[1:0] != 2'b11 SHALL be classified illegal.
REQ-019 EXECUTE: exactly one unit_enable_n bit low, selected by opcode; one settle cycle; then go WRITEBACK.
REQ-020 WRITEBACK: same enable bit still low; wb_we=1 for exactly one cycle; pc<=pc+4; then go FETCH.
REQ-021 wb_we SHALL be suppressed when instruction[11:7]==0 (x0); all other WRITEBACK behaviour is unchanged.
REQ-022 pc+4 SHALL wrap modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 TRAP: illegal=1, all enables high, mem_req=0; remain in TRAP until reset.
REQ-024 Outside EXECUTE/WRITEBACK, all unit_enable_n bits SHALL be 1; at no time SHALL more than one bit be 0.
REQ-025 mem_ack while mem_req=0 SHALL be ignored.
REQ-026 instruction SHALL change only on an accepted fetch.
REQ-027 Minimum throughput is 4 cycles per instruction, when mem_ack arrives in the first FETCH cycle.

Reset
REQ-028 When rst_n=0: state=FETCH, pc=RESET_PC, instruction=0, unit_enable_n=4'b1111, wb_we=0, illegal=0.
REQ-029 While rst_n=0, mem_req SHALL be held at 0.
REQ-030 mem_req SHALL rise in the first cycle after rst_n deasserts.
REQ-031 Reset asserted mid-instruction SHALL abort immediately: no wb_we pulse and no PC increment.

Structure
REQ-032 Package cpu_pkg SHALL hold XLEN, REG_SELECT_LEN, opcode constants, the unit index enum and the state enum.
REQ-033 SHALL contain one combinational sub-module, opcode_decoder: instruction -> 4-bit one-hot unit select plus illegal.

Verification
REQ-034 Reset, then fetch with mem_ack same cycle, mem_rdata=32'h123450B7 (lui x1) -> unit_enable_n=4'b1110 for 2 cycles, one wb_we pulse, pc 0->4, next mem_req 4 cycles after the first.
REQ-035 mem_ack delayed 3 cycles -> mem_req and mem_addr held stable; instruction unchanged until the ack edge.
REQ-036 Fetch 32'h00000037 (lui x0) -> unit_enable_n=4'b1110 in EXECUTE/WRITEBACK, wb_we stays 0, pc still increments by 4.
REQ-037 Fetch 32'hFFFFFFFF -> TRAP, illegal=1, mem_req=0 permanently; rst_n pulse clears illegal and pc=RESET_PC.
REQ-038 RESET_PC=32'hFFFF_FFFC, execute one addi (32'h00100093) -> unit_enable_n=4'b1011, pc wraps to 32'h0000_0000.
REQ-039 Assert rst_n=0 during EXECUTE -> enables go 4'b1111 asynchronously, no wb_we, pc=RESET_PC.
